pc_controller: RTL and testbench

PC_CONTROLLER -- requirements
Module: pc_controller

---
 rtl/pc_controller_pkg.sv | 21 ++
 rtl/program_counter.sv | 28 ++
 rtl/pc_controller.sv | 134 +++++++++++++
 tb/tb_pc_controller.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_controller_pkg.sv
// Shared constants for the fetch-side PC controller: FSM encodings,
// default reset/exception vectors and the sequential PC increment.
package pc_controller_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2,
        ST_HALT  = 2'd3
    } pc_state_e;

    localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] PC_EXC_VECTOR   = 32'h0000_0080;
    localparam logic [31:0] PC_INCR         = 32'd4;

    // Instruction addresses must be word aligned.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/program_counter.sv
// Fetch address register: loads next_address every cycle, async reset to RESET_VALUE.
module program_counter #(
    parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] next_address,
    output logic [31:0] current_address
);

    logic [31:0] addr_q;
    logic [31:0] addr_d;

    always_comb begin
        addr_d = next_address;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= RESET_VALUE;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign current_address = addr_q;

endmodule

// File: rtl/pc_controller.sv
// Next-PC selection and BOOT/RUN/STALL/HALT sequencing around the program_counter register.
module pc_controller
    import pc_controller_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = PC_RESET_VECTOR,
    parameter logic [31:0] EXC_VECTOR   = PC_EXC_VECTOR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        exception,
    input  logic        halt_req,
    input  logic        resume,
    output logic [31:0] pc,
    output logic        pc_valid,
    output logic        flush,
    output logic [31:0] epc,
    output logic [1:0]  state
);

    pc_state_e   state_q, state_d;
    logic        pc_valid_q, pc_valid_d;
    logic        flush_q, flush_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] pc_d;

    logic        redirect;
    logic [31:0] redirect_target;
    logic        bad_target;
    logic        take_trap;
    logic [31:0] pc_seq;

    program_counter #(
        .RESET_VALUE (RESET_VECTOR)
    ) u_pc (
        .clk             (clk),
        .reset           (reset),
        .next_address    (pc_d),
        .current_address (pc)
    );

    always_comb begin
        // Jump outranks branch, so only the selected target's alignment matters.
        redirect        = jump | branch_taken;
        redirect_target = jump ? jump_target : branch_target;
        bad_target      = redirect && is_misaligned(redirect_target);
        pc_seq          = pc + PC_INCR;
        take_trap       = 1'b0;
        if (state_q != ST_BOOT) begin
            take_trap = exception || (state_q != ST_HALT && bad_target);
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc;
        pc_valid_d = pc_valid_q;
        flush_d    = 1'b0;
        epc_d      = epc_q;

        if (take_trap) begin
            state_d    = ST_RUN;
            pc_d       = EXC_VECTOR;
            pc_valid_d = 1'b1;
            flush_d    = 1'b1;
            epc_d      = pc;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    state_d    = ST_RUN;
                    pc_d       = RESET_VECTOR;
                    pc_valid_d = 1'b1;
                end
                ST_RUN, ST_STALL: begin
                    if (redirect) begin
                        state_d    = ST_RUN;
                        pc_d       = redirect_target;
                        pc_valid_d = 1'b1;
                        flush_d    = 1'b1;
                    end else if (halt_req && !resume) begin
                        state_d    = ST_HALT;
                        pc_valid_d = 1'b0;
                    end else if (stall) begin
                        state_d    = ST_STALL;
                        pc_valid_d = 1'b1;
                    end else begin
                        state_d    = ST_RUN;
                        pc_d       = pc_seq;
                        pc_valid_d = 1'b1;
                    end
                end
                ST_HALT: begin
                    // Simultaneous halt_req and resume cancel out.
                    if (resume && !halt_req) begin
                        state_d    = ST_RUN;
                        pc_d       = pc_seq;
                        pc_valid_d = 1'b1;
                    end else begin
                        pc_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d    = ST_BOOT;
                    pc_d       = RESET_VECTOR;
                    pc_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_BOOT;
            pc_valid_q <= 1'b0;
            flush_q    <= 1'b0;
            epc_q      <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_valid_q <= pc_valid_d;
            flush_q    <= flush_d;
            epc_q      <= epc_d;
        end
    end

    assign pc_valid = pc_valid_q;
    assign flush    = flush_q;
    assign epc      = epc_q;
    assign state    = state_q;

endmodule

// File: tb/tb_pc_controller.sv
// Self-checking bench for pc_controller: vector table replayed through a scoreboard queue,
// plus hand-written asynchronous reset sequences.
module tb_pc_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = 32'h0;
    logic        exception = 1'b0;
    logic        halt_req = 1'b0;
    logic        resume = 1'b0;
    logic [31:0] pc;
    logic        pc_valid;
    logic        flush;
    logic [31:0] epc;
    logic [1:0]  state;

    int tests_run = 0;
    int tests_failed = 0;

    localparam logic [1:0] B = 2'd0, R = 2'd1, S = 2'd2, H = 2'd3;

    typedef struct {
        logic        st;
        logic        br;
        logic [31:0] bt;
        logic        j;
        logic [31:0] jt;
        logic        exc;
        logic        hr;
        logic        rs;
        logic [31:0] pc;
        logic        vld;
        logic        fl;
        logic [31:0] epc;
        logic [1:0]  state;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic        vld;
        logic        fl;
        logic [31:0] epc;
        logic [1:0]  state;
        int          idx;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    pc_controller dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .exception     (exception),
        .halt_req      (halt_req),
        .resume        (resume),
        .pc            (pc),
        .pc_valid      (pc_valid),
        .flush         (flush),
        .epc           (epc),
        .state         (state)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic st, input logic br, input logic [31:0] bt,
                                input logic j, input logic [31:0] jt, input logic exc,
                                input logic hr, input logic rs, input logic [31:0] epc_pc,
                                input logic vld, input logic fl, input logic [31:0] e,
                                input logic [1:0] s);
        vec_t v;
        v.st = st; v.br = br; v.bt = bt; v.j = j; v.jt = jt; v.exc = exc;
        v.hr = hr; v.rs = rs; v.pc = epc_pc; v.vld = vld; v.fl = fl; v.epc = e; v.state = s;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " pc"},       pc,               32'h0);
        chk({tag, " pc_valid"}, {31'h0, pc_valid}, 32'h0);
        chk({tag, " flush"},    {31'h0, flush},    32'h0);
        chk({tag, " epc"},      epc,              32'h0);
        chk({tag, " state"},    {30'h0, state},    32'h0);
    endtask

    task automatic drive_idle();
        stall = 0; branch_taken = 0; branch_target = 0; jump = 0; jump_target = 0;
        exception = 0; halt_req = 0; resume = 0;
    endtask

    // Drive one vector just after an edge, queue its expectation, then check after the next edge.
    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        exp_t got;
        stall = v.st; branch_taken = v.br; branch_target = v.bt; jump = v.j;
        jump_target = v.jt; exception = v.exc; halt_req = v.hr; resume = v.rs;
        e.pc = v.pc; e.vld = v.vld; e.fl = v.fl; e.epc = v.epc; e.state = v.state; e.idx = idx;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk($sformatf("v%0d pc", got.idx),       pc,               got.pc);
        chk($sformatf("v%0d pc_valid", got.idx), {31'h0, pc_valid}, {31'h0, got.vld});
        chk($sformatf("v%0d flush", got.idx),    {31'h0, flush},    {31'h0, got.fl});
        chk($sformatf("v%0d epc", got.idx),      epc,              got.epc);
        chk($sformatf("v%0d state", got.idx),    {30'h0, state},    {30'h0, got.state});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //          st br bt           j  jt            exc hr rs  pc            v  f  epc           state
        vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,        0, 0, 0, 32'h0000_0000, 1, 0, 32'h0,        R)); // leave BOOT
        vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,        0, 0, 0, 32'h0000_0004, 1, 0, 32'h0,        R));
        vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,        0, 0, 0, 32'h0000_0008, 1, 0, 32'h0,        R));
        vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,        0, 0, 0, 32'h0000_000C, 1, 0, 32'h0,        R));
        vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,        0, 0, 0, 32'h0000_0010, 1, 0, 32'h0,        R));
        vecs.push_back(mk(1, 0, 32'h0,   0, 32'h0,        0, 0, 0, 32'h0000_0010, 1, 0, 32'h0,        S)); // stall x3
        vecs.push_back(mk(1, 0, 32'h0,   0, 32'h0,        0, 0, 0, 32'h0000_0010, 1, 0, 32'h0,        S));
        vecs.push_back(mk(1, 0, 32'h0,   0, 32'h0,        0, 0, 0, 32'h0000_0010, 1, 0, 32'h0,        S));
        vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,        0, 0, 0, 32'h0000_0014, 1, 0, 32'h0,        R));
        vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,        0, 0, 0, 32'h0000_0018, 1, 0, 32'h0,        R));
        vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,        0, 0, 0, 32'h0000_001C, 1, 0, 32'h0,        R));
        vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,        0, 0, 0, 32'h0000_0020, 1, 0, 32'h0,        R));
        vecs.push_back(mk(1, 1, 32'h100, 1, 32'h200,      0, 0, 0, 32'h0000_0200, 1, 1, 32'h0,        R)); // jump beats branch and stall
        vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,        0, 0, 0, 32'h0000_0204, 1, 0, 32'h0,        R));
        vecs.push_back(mk(0, 0, 32'h0,   1, 32'h40,       0, 0, 0, 32'h0000_0040, 1, 1, 32'h0,        R));
        vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,        1, 0, 0, 32'h0000_0080, 1, 1, 32'h40,       R)); // exception
        vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,        0, 0, 0, 32'h0000_0084, 1, 0, 32'h40,       R));
        vecs.push_back(mk(0, 0, 32'h0,   1, 32'h103,      0, 0, 0, 32'h0000_0080, 1, 1, 32'h84,       R)); // misaligned jump
        vecs.push_back(mk(0, 1, 32'h40,  0, 32'h0,        0, 0, 0, 32'h0000_0040, 1, 1, 32'h84,       R));
        vecs.push_back(mk(0, 1, 32'h42,  0, 32'h0,        0, 0, 0, 32'h0000_0080, 1, 1, 32'h40,       R)); // misaligned branch
        vecs.push_back(mk(0, 0, 32'h0,   1, 32'hFFFF_FFFC, 0, 0, 0, 32'hFFFF_FFFC, 1, 1, 32'h40,      R));
        vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,        0, 0, 0, 32'h0000_0000, 1, 0, 32'h40,       R)); // wrap
        vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,        0, 1, 0, 32'h0000_0000, 0, 0, 32'h40,       H)); // halt
        vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,        0, 0, 0, 32'h0000_0000, 0, 0, 32'h40,       H));
        vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,        0, 1, 1, 32'h0000_0000, 0, 0, 32'h40,       H)); // both: no effect
        vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,        0, 0, 1, 32'h0000_0004, 1, 0, 32'h40,       R)); // resume
        vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,        0, 1, 1, 32'h0000_0008, 1, 0, 32'h40,       R)); // both in RUN: no effect
        vecs.push_back(mk(1, 0, 32'h0,   0, 32'h0,        0, 0, 0, 32'h0000_0008, 1, 0, 32'h40,       S));
        vecs.push_back(mk(1, 0, 32'h0,   0, 32'h0,        0, 1, 0, 32'h0000_0008, 0, 0, 32'h40,       H)); // halt from STALL
        vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,        1, 0, 0, 32'h0000_0080, 1, 1, 32'h8,        R)); // trap from HALT
        vecs.push_back(mk(1, 0, 32'h0,   0, 32'h0,        1, 0, 0, 32'h0000_0080, 1, 1, 32'h80,       R)); // back-to-back trap
        vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,        0, 0, 0, 32'h0000_0084, 1, 0, 32'h80,       R));
        vecs.push_back(mk(1, 0, 32'h0,   0, 32'h0,        0, 0, 0, 32'h0000_0084, 1, 0, 32'h80,       S));
        vecs.push_back(mk(1, 0, 32'h0,   0, 32'h0,        1, 0, 0, 32'h0000_0080, 1, 1, 32'h84,       R)); // trap from STALL
        vecs.push_back(mk(1, 0, 32'h0,   1, 32'h300,      0, 0, 0, 32'h0000_0300, 1, 1, 32'h84,       R));
        vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,        0, 1, 0, 32'h0000_0300, 0, 0, 32'h84,       H));

        drive_idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("in_reset");
        reset = 1'b0;
        #1;
        chk_reset_outputs("boot");

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end
        drive_idle();

        // Asynchronous reset between edges while halted.
        #3;
        reset = 1'b1;
        #1;
        chk_reset_outputs("async_halt");
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        apply(mk(0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 32'h0, 1, 0, 32'h0, R), 100);
        apply(mk(0, 0, 32'h0, 1, 32'h500, 0, 0, 0, 32'h500, 1, 1, 32'h0, R), 101);
        drive_idle();

        // Reset during a live flush pulse must clear it immediately.
        #2;
        reset = 1'b1;
        #1;
        chk_reset_outputs("async_flush");
        @(posedge clk);
        #1;
        reset = 1'b0;
        apply(mk(1, 0, 32'h0, 0, 32'h0, 0, 0, 0, 32'h0, 1, 0, 32'h0, R), 102);
        apply(mk(1, 0, 32'h0, 0, 32'h0, 0, 0, 0, 32'h0, 1, 0, 32'h0, S), 103);
        drive_idle();

        // Reset during STALL.
        #2;
        reset = 1'b1;
        #1;
        chk_reset_outputs("async_stall");
        @(posedge clk);
        #1;
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
